// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI-lite read channel (ar/r) of the SRAM between
// N requesters (index 0 = LSU load, index 1 = IFU fetch). Exactly one read is
// outstanding at a time; every transaction passes through IDLE -> ADDR -> DATA.
// The slave-side request is driven only from registered state (grant and latched
// address), so there is no combinational path from m_arvalid to s_arvalid.
// Build option: define ARB_RR_EN for round-robin arbitration with a last_grant
// register; without it, fixed priority (lowest index wins) and no extra state.
module axi_rd_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RW = 2,
    localparam int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    // master side
    input  logic [N*AW-1:0]   m_araddr,
    input  logic [N-1:0]      m_arvalid,
    output logic [N-1:0]      m_arready,
    output logic [N*DW-1:0]   m_rdata,
    output logic [N*RW-1:0]   m_rresp,
    output logic [N-1:0]      m_rvalid,
    input  logic [N-1:0]      m_rready,
    // slave side
    output logic [AW-1:0]     s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DW-1:0]     s_rdata,
    input  logic [RW-1:0]     s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    // status
    output logic [GW-1:0]     grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [GW-1:0]   win;
    logic            win_found;
    logic            any_req;

`ifdef ARB_RR_EN
    logic [GW-1:0]   last_grant_q, last_grant_d;
    int              rr_idx;
`endif

    assign any_req = |m_arvalid;

`ifdef ARB_RR_EN
    // Round-robin pick: first requester searching upward from last_grant+1, wrapping at N.
    always_comb begin
        win       = last_grant_q;
        win_found = 1'b0;
        rr_idx    = 0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = (int'(last_grant_q) + k) % N;
            if (!win_found && m_arvalid[rr_idx]) begin
                win       = GW'(rr_idx);
                win_found = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: the lowest-indexed requester wins, so the LSU beats the IFU.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && m_arvalid[i]) begin
                win       = GW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    // Next-state logic: grant and address are captured only in IDLE, so requests
    // arriving in ADDR or DATA wait for the next IDLE cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = win;
                    addr_d  = m_araddr[int'(win)*AW +: AW];
                    state_d = ADDR;
`ifdef ARB_RR_EN
                    last_grant_d = win;
`endif
                end
            end
            ADDR: begin
                // s_arvalid is always high here, so s_arready alone completes the handshake
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_rvalid && m_rready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output steering: only the granted master's slices are ever non-zero, and
    // everything is zero in IDLE (including while reset holds state at IDLE).
    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        case (state_q)
            ADDR: begin
                // latched address is held even if the master withdraws its request
                s_araddr           = addr_q;
                s_arvalid          = 1'b1;
                m_arready[grant_q] = s_arready;
            end
            DATA: begin
                m_rvalid[grant_q]                 = s_rvalid;
                s_rready                          = m_rready[grant_q];
                m_rdata[int'(grant_q)*DW +: DW]   = s_rdata;
                m_rresp[int'(grant_q)*RW +: RW]   = s_rresp;
            end
            default: begin
            end
        endcase
    end

    // Control state: FSM and grant owner, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin history: owner of the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Address latch: data only, never observed outside ADDR, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    // Structural invariants of the steering logic.
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_rvalid));
    a_arready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_arready));
    a_grant_range: assert property (@(posedge clk) disable iff (rst) int'(grant_q) < N);

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI-lite-style read channel (ar/r) of the instruction/data SRAM between N requesters (IFU fetch, LSU load).
- Sits between the masters and the SRAM read port, and grants exactly one outstanding read at a time.
- Write channels bypass this block.

Parameters:
- N, 2, number of requesting masters (2..8)
- AW, 32, address width
- DW, 32, data width
- RW, 2, read response width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_araddr  in  N*AW  per-master read address; slice i belongs to master i
- m_arvalid  in  N  per-master address valid
- m_arready  out  N  per-master address ready
- m_rdata  out  N*DW  per-master read data
- m_rresp  out  N*RW  per-master read response
- m_rvalid  out  N  per-master read data valid
- m_rready  in  N  per-master read data ready
- s_araddr  out  AW  slave read address
- s_arvalid  out  1  slave address valid
- s_arready  in  1  slave address ready
- s_rdata  in  DW  slave read data
- s_rresp  in  RW  slave read response
- s_rvalid  in  1  slave read valid
- s_rready  out  1  slave read ready
- grant_id  out  clog2(N) (min 1)  index of the current owner; debug only
- busy  out  1  high while state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, grant_id=0, all outputs 0 (s_arvalid, s_rready, m_arready, m_rvalid, m_rdata, m_rresp, busy).
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is set, pick winner g per the arbitration rule, register grant_id=g, go to ADDR.
  - Outputs stay 0 during IDLE.
- ADDR:
  - s_araddr = m_araddr[g]; s_arvalid = 1.
  - m_arready[g] = s_arready; every other m_arready = 0.
  - On s_arvalid & s_arready, go to DATA.
- DATA:
  - m_rvalid[g] = s_rvalid; s_rready = m_rready[g].
  - m_rdata[g] = s_rdata and m_rresp[g] = s_rresp; other slices are 0.
  - On s_rvalid & s_rready, go to IDLE.
- Latency: m_arvalid seen at edge t gives s_arvalid high in cycle t+1.
  - The slave path is combinational from the registered grant.
  - One IDLE cycle always separates consecutive transactions.
- Arbitration (default): fixed priority, lowest index wins. Connect the LSU to index 0 and the IFU to index 1.
- Masters must hold m_arvalid/m_araddr stable until handshake (AXI rule).
  - If a granted master drops arvalid in ADDR, the arbiter still holds s_arvalid and s_araddr (s_araddr is latched into a register at grant) until the slave accepts.
  - The resulting read data is still returned to g.
- Simultaneous requests in IDLE: only the winner is granted. Losers see arready=0 and remain pending.
- A new request arriving in ADDR or DATA is not granted until the next IDLE.
- Slave error (s_rresp != 0) is passed through unchanged. The arbiter does not retry.
- Reset mid-transaction returns to IDLE immediately. The slave must be reset by the same rst, so no orphan beat can occur.
- No combinational path from m_arvalid to s_arvalid.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset 0) is kept, and the winner is the first requester searching from last_grant+1 modulo N. last_grant updates on each grant.
- Undefined: fixed priority as above, and no last_grant register is built.

Test Plan:
- Single read: N=2, m1 requests addr 0x80000004, slave returns 0x00000413 (resp 0) after 2 cycles -> s_arvalid 1 cycle after request, m_rvalid[1]=1 with data 0x00000413, m_rvalid[0] stays 0, busy falls after the r handshake.
- Simultaneous requests: m0 reads 0x80001000 and m1 reads 0x80000000 in the same cycle -> m0 served first; m1 granted in the IDLE cycle after m0's r handshake; each receives only its own data.
- Backpressure: s_arready held low 5 cycles, then m_rready[g] low 3 cycles while s_rvalid=1 -> s_arvalid and s_araddr stable throughout; s_rready=0 until m_rready rises; exactly one transfer completes.
- Error response: slave returns rresp=2 -> m_rresp[g]=2 and the FSM returns to IDLE normally.
- Async reset asserted in DATA -> all outputs 0 the same cycle, no clock edge needed; after release, a fresh request completes correctly.
- ARB_RR_EN: both masters request continuously for 4 transactions -> grant order 1,0,1,0 (from reset last_grant=0); without the macro, order is 0,0,0,0.
